// File: rtl/placement_pkg.sv
// Shared types and defaults for the placement read-back path.
package placement_pkg;

  localparam int N_DEF = 4;
  localparam int V_DEF = 11;
  localparam int W_DEF = 32;
  localparam int EMPTY_CELL = -1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    GWAIT,
    PRD,
    PWAIT,
    EMIT,
    ADV,
    DONE
  } state_t;

endpackage

// File: rtl/placement_export_if.sv
// Beat stream (node, x, y) with valid/ready handshake.
interface placement_export_if #(
  parameter int W = 32
) ();

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_node;
  logic [W-1:0] out_x;
  logic [W-1:0] out_y;

  modport master (
    output out_valid,
    output out_node,
    output out_x,
    output out_y,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_node,
    input  out_x,
    input  out_y,
    output out_ready
  );

endinterface

// File: rtl/grid_scan_counter.sv
// Row-major x/y walker over an N x N grid with a last-cell flag.
module grid_scan_counter
  import placement_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         last
);

  localparam logic [W-1:0] TOP = W'(N - 1);

  assign last = (x == TOP) && (y == TOP);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (inc && !last) begin
      if (y == TOP) begin
        y <= '0;
        x <= x + 1'b1;
      end else begin
        y <= y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/placement_export.sv
// Streams occupied grid cells as (node, x, y) beats.
// Define PLACEMENT_EXPORT_CHECK_EN to cross-check against pos_X/pos_Y.
module placement_export
  import placement_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int V = V_DEF,
  parameter int W = W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                grid_re,
  output logic [W-1:0]        grid_addr,
  input  logic signed [W-1:0] grid_data,
  output logic                px_re,
  output logic [W-1:0]        px_addr,
  input  logic signed [W-1:0] px_data,
  output logic                py_re,
  output logic [W-1:0]        py_addr,
  input  logic signed [W-1:0] py_data,
  output logic [W-1:0]        placed_count,
  output logic [W-1:0]        mismatch_count,
  output logic                error,
  placement_export_if.master  ob
);

  localparam logic [W-1:0] NW = W'(N);
  localparam logic signed [W-1:0] EMPTY = W'(EMPTY_CELL);
  localparam logic signed [W-1:0] VS = W'(V);

  state_t state, nxt;

  logic [W-1:0] x, y;
  logic         last;
  logic [W-1:0] node_q;
  logic         kick;
  logic         is_empty;
  logic         is_bad;

  assign kick     = (state == IDLE) && start;
  assign is_empty = (grid_data == EMPTY);
  assign is_bad   = !is_empty &&
                    ((grid_data < 0) || (grid_data >= VS));

  grid_scan_counter #(
    .N(N),
    .W(W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (kick),
    .inc   (state == ADV),
    .x     (x),
    .y     (y),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = SCAN;
      SCAN:  nxt = GWAIT;
      GWAIT: begin
        if (is_empty || is_bad) nxt = ADV;
`ifdef PLACEMENT_EXPORT_CHECK_EN
        else                    nxt = PRD;
`else
        else                    nxt = EMIT;
`endif
      end
      PRD:   nxt = PWAIT;
      PWAIT: nxt = EMIT;
      EMIT:  if (ob.out_ready) nxt = ADV;
      ADV:   nxt = last ? DONE : SCAN;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign grid_re   = (state == SCAN);
  assign grid_addr = grid_re ? (x * NW + y) : '0;

  assign ob.out_valid = (state == EMIT);
  assign ob.out_node  = node_q;
  assign ob.out_x     = x;
  assign ob.out_y     = y;

  always_ff @(posedge clk) begin
    if (reset) begin
      node_q       <= '0;
      placed_count <= '0;
      error        <= 1'b0;
    end else begin
      if (kick) begin
        placed_count <= '0;
        error        <= 1'b0;
      end
      if (state == GWAIT) begin
        node_q <= grid_data;
        if (is_bad) error <= 1'b1;
      end
      if (ob.out_valid && ob.out_ready)
        placed_count <= placed_count + 1'b1;
    end
  end

`ifdef PLACEMENT_EXPORT_CHECK_EN
  logic [W-1:0] mism_q;

  assign px_re          = (state == PRD);
  assign py_re          = (state == PRD);
  assign px_addr        = px_re ? node_q : '0;
  assign py_addr        = py_re ? node_q : '0;
  assign mismatch_count = mism_q;

  // coordinates compare as signed so negative stored positions never match
  always_ff @(posedge clk) begin
    if (reset || kick) begin
      mism_q <= '0;
    end else if (state == PWAIT) begin
      if ((px_data != $signed(x)) || (py_data != $signed(y)))
        mism_q <= mism_q + 1'b1;
    end
  end
`else
  logic unused_pos;

  assign px_re          = 1'b0;
  assign py_re          = 1'b0;
  assign px_addr        = '0;
  assign py_addr        = '0;
  assign mismatch_count = '0;
  assign unused_pos     = ^{px_data, py_data};
`endif

endmodule

// File: tb/tb_placement_export.sv
// Directed bench for placement_export with synchronous-read RAM models.
module tb_placement_export;
  import placement_pkg::*;

  localparam int W = 32;

`ifdef PLACEMENT_EXPORT_CHECK_EN
  localparam int OCC_EXTRA = 3;
  localparam int MISM_EXP = 1;
`else
  localparam int OCC_EXTRA = 1;
  localparam int MISM_EXP = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, error;
  logic grid_re, px_re, py_re;
  logic [W-1:0] grid_addr, px_addr, py_addr;
  logic signed [W-1:0] grid_data, px_data, py_data;
  logic [W-1:0] placed_count, mismatch_count;

  logic [W-1:0] grid_mem [16];
  logic [W-1:0] px_mem [16];
  logic [W-1:0] py_mem [16];

  int total = 0;
  int bad = 0;
  int nbeats = 0;
  logic [W-1:0] bn, bx, by;

  placement_export_if #(.W(W)) ob ();

  placement_export dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .grid_re        (grid_re),
    .grid_addr      (grid_addr),
    .grid_data      (grid_data),
    .px_re          (px_re),
    .px_addr        (px_addr),
    .px_data        (px_data),
    .py_re          (py_re),
    .py_addr        (py_addr),
    .py_data        (py_data),
    .placed_count   (placed_count),
    .mismatch_count (mismatch_count),
    .error          (error),
    .ob             (ob.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (grid_re) grid_data <= grid_mem[grid_addr[3:0]];
    if (px_re)   px_data   <= px_mem[px_addr[3:0]];
    if (py_re)   py_data   <= py_mem[py_addr[3:0]];
  end

  always @(posedge clk) begin
    if (!reset && ob.out_valid && ob.out_ready) begin
      nbeats = nbeats + 1;
      bn = ob.out_node;
      bx = ob.out_x;
      by = ob.out_y;
    end
  end

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      grid_mem[i] = 32'hFFFF_FFFF;
      px_mem[i] = '0;
      py_mem[i] = '0;
    end
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = 0;
    for (int c = 1; c <= 400; c++) begin
      if (done) begin
        at = c;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", W'(at != 0), 1);
  endtask

  task automatic wait_valid();
    int ok = 0;
    for (int c = 0; c < 100; c++) begin
      if (ob.out_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("valid_seen", W'(ok), 1);
  endtask

  initial begin
    int at;
    int b0;
    grid_data = '0;
    px_data = '0;
    py_data = '0;
    ob.out_ready = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_valid", W'(ob.out_valid), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_gaddr", grid_addr, 0);
    chk("rst_placed", placed_count, 0);
    chk("rst_err", W'(error), 0);
    reset = 1'b0;
    @(negedge clk);

    // empty grid
    b0 = nbeats;
    kick();
    chk("e_busy", W'(busy), 1);
    chk("e_gre", W'(grid_re), 1);
    wait_done(at);
    chk("e_lat", W'(at), 49);
    @(negedge clk);
    chk("e_busy_end", W'(busy), 0);
    chk("e_beats", W'(nbeats - b0), 0);
    chk("e_placed", placed_count, 0);
    chk("e_err", W'(error), 0);

    // one node at addr 6 -> x=1 y=2, positions agree
    grid_mem[6] = 3;
    px_mem[3] = 1;
    py_mem[3] = 2;
    b0 = nbeats;
    kick();
    wait_done(at);
    chk("o_lat", W'(at), W'(49 + OCC_EXTRA));
    chk("o_beats", W'(nbeats - b0), 1);
    chk("o_node", bn, 3);
    chk("o_x", bx, 1);
    chk("o_y", by, 2);
    chk("o_placed", placed_count, 1);
    chk("o_mism", mismatch_count, 0);
    @(negedge clk);

    // stored x disagrees; beat still goes out
    px_mem[3] = 0;
    b0 = nbeats;
    kick();
    wait_done(at);
    chk("m_beats", W'(nbeats - b0), 1);
    chk("m_node", bn, 3);
    chk("m_x", bx, 1);
    chk("m_y", by, 2);
    chk("m_mism", mismatch_count, W'(MISM_EXP));
    @(negedge clk);

    // backpressure on cell 0
    clear_mem();
    grid_mem[0] = 5;
    ob.out_ready = 1'b0;
    b0 = nbeats;
    kick();
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", W'(ob.out_valid), 1);
      chk("bp_node", ob.out_node, 5);
      chk("bp_x", ob.out_x, 0);
      chk("bp_y", ob.out_y, 0);
      if (i == 5) ob.out_ready = 1'b1;
      else @(negedge clk);
    end
    wait_done(at);
    chk("bp_beats", W'(nbeats - b0), 1);
    chk("bp_placed", placed_count, 1);
    @(negedge clk);

    // out-of-range id in the last cell
    clear_mem();
    grid_mem[15] = 11;
    b0 = nbeats;
    kick();
    wait_done(at);
    chk("x_lat", W'(at), 49);
    chk("x_err", W'(error), 1);
    chk("x_beats", W'(nbeats - b0), 0);
    chk("x_placed", placed_count, 0);
    @(negedge clk);

    // reset while a beat is stalled in EMIT
    clear_mem();
    grid_mem[6] = 3;
    px_mem[3] = 1;
    py_mem[3] = 2;
    ob.out_ready = 1'b0;
    b0 = nbeats;
    kick();
    wait_valid();
    reset = 1'b1;
    @(negedge clk);
    chk("r_valid", W'(ob.out_valid), 0);
    chk("r_busy", W'(busy), 0);
    chk("r_err", W'(error), 0);
    chk("r_placed", placed_count, 0);
    chk("r_beats", W'(nbeats - b0), 0);
    reset = 1'b0;
    ob.out_ready = 1'b1;
    @(negedge clk);
    kick();
    chk("r_gre", W'(grid_re), 1);
    chk("r_gaddr", grid_addr, 0);
    wait_done(at);
    chk("r2_beats", W'(nbeats - b0), 1);
    chk("r2_placed", placed_count, 1);
    chk("r2_node", bn, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/placement_export.md
# placement_export

Read-back engine for a finished placement: walks the grid RAM cell by cell in address order and streams every occupied cell out as a (node, x, y) beat over a valid/ready interface. With the check feature compiled in, it also cross-checks each beat against the pos_X/pos_Y RAMs and counts mismatches. It sits after the placement engine, on the read side of the same grid and position memories, and feeds a host or log sink once placement is done.

## Interface
- N, 4, grid side; the grid holds N*N cells, cell address = x*N + y
- V, 11, node count; valid node ids are 0..V-1
- W, 32, data and address width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin a scan; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE is exited
- done  out  1  one-cycle pulse in DONE
- grid_re  out  1  grid read enable
- grid_addr  out  W  grid cell address
- grid_data  in  W signed  grid cell contents; -1 means empty
- px_re, py_re  out  1  position RAM read enables
- px_addr, py_addr  out  W  node id
- px_data, py_data  in  W signed  stored x / y of the node
- out_valid  out  1  beat available
- out_ready  in  1  sink accepts the beat
- out_node, out_x, out_y  out  W  beat payload
- placed_count  out  W  number of beats accepted
- mismatch_count  out  W  number of position cross-check failures
- error  out  1  sticky; set when a grid cell holds an id outside 0..V-1 other than -1

## Operation
- All memories have synchronous reads: data is valid in the cycle after the re/addr cycle. The block drives re/addr as Moore decodes of the state.
- IDLE: when start=1, clear x, y, placed_count, mismatch_count and error, then go to SCAN.
- SCAN: grid_re=1, grid_addr=x*N+y. Go to GWAIT.
- GWAIT: latch grid_data as node.
  - node == -1: go to ADV.
  - node < 0 or node >= V: set error, go to ADV.
  - otherwise: go to PRD when the check feature is compiled in, else to EMIT.
- PRD: px_re=py_re=1, px_addr=py_addr=node. Go to PWAIT.
- PWAIT: if px_data != x or py_data != y, increment mismatch_count. Go to EMIT. The beat is emitted either way.
- EMIT: out_valid=1 with payload node/x/y. On out_ready=1, increment placed_count and go to ADV.
- ADV: if x==N-1 and y==N-1, go to DONE. Otherwise increment y; when y wraps from N-1 to 0, increment x. Then go to SCAN.
- DONE: done=1, then go to IDLE. Counters and error hold their values until the next start.
- start while busy is ignored.

## Timing
- Reset values: out_valid=0, done=0, busy=0, all re=0, all addresses 0, payload 0, all counters 0, error=0, state IDLE.
- Cycles per cell with out_ready held high:
  - empty or invalid cell: 3 (SCAN, GWAIT, ADV)
  - occupied cell, check compiled in: 6 (SCAN, GWAIT, PRD, PWAIT, EMIT, ADV)
  - occupied cell, check compiled out: 4
- Empty N=4 grid: done pulses 49 cycles after the start-sampling edge.
- Backpressure: while out_valid=1 and out_ready=0, the payload is held stable. There is no combinational path from out_ready to out_valid.
- Reset mid-scan: on the next edge all outputs return to their reset values. A partially presented beat is dropped.
- Arithmetic: counters are unsigned W-bit and wrap. The coordinate comparison is signed.

## Configuration
- PLACEMENT_EXPORT_CHECK_EN defined: PRD/PWAIT are included and mismatch_count is live.
- PLACEMENT_EXPORT_CHECK_EN not defined:
  - PRD/PWAIT are removed; GWAIT goes directly to EMIT.
  - px_re/py_re are tied to 0; px_addr/py_addr are tied to 0.
  - mismatch_count is a constant 0.

## Structure
- Shared package placement_pkg:
  - EMPTY_CELL = -1
  - default N, V, W
  - state enum: IDLE, SCAN, GWAIT, PRD, PWAIT, EMIT, ADV, DONE
- Sub-module grid_scan_counter: x/y counters with an increment input and a last-cell flag; also reusable by the evaluation path.

## Test plan
- All 16 cells = -1, start -> no beats, placed_count=0, error=0, done pulses 49 cycles after the start edge.
- Cell addr 6 = 3, px[3]=1, py[3]=2, check on -> one beat node=3 x=1 y=2, mismatch_count=0, placed_count=1.
- Same grid with px[3]=0 -> beat still node=3 x=1 y=2, mismatch_count=1.
- Cell addr 0 = 5 with out_ready held low 5 cycles -> out_valid high and payload 5/0/0 stable for 6 cycles, exactly one beat accepted.
- Cell addr 15 = 11 (>= V) -> error=1, no beat for that cell, done still pulses.
- reset asserted while in EMIT -> next cycle out_valid=0, busy=0, counters 0; a following start rescans from addr 0.
